mul_div_unit: RTL

//  Iterative multiply/divide unit for the EX stage of the 5-stage MIPS pipeline; executes mult, multu, div, divu.

---
 rtl/mul_div_unit.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO for the MIPS EX stage.
// Optional abort input flush_i is compiled in when MULDIV_FLUSH_EN is defined.
module mul_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [1:0]            op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  hi_we_i,
  input  logic                  lo_we_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
`ifdef MULDIV_FLUSH_EN
  input  logic                  flush_i,
`endif
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  div_zero_o,
  output logic [DATA_WIDTH-1:0] hi_o,
  output logic [DATA_WIDTH-1:0] lo_o
);
  // state | meaning
  // IDLE  | waiting for start, HI/LO writable
  // RUN   | one shift-add / shift-subtract iteration per cycle
  // FIX   | sign correction, HI/LO written
  // DONE  | result valid for one cycle, new start accepted
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

  state_t          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic            sa_q, sa_d, sb_q, sb_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [W-1:0]    opnd_q, opnd_d;
  logic [W-1:0]    hi_q, hi_d, lo_q, lo_d;
  logic            div_zero_q, div_zero_d;

  logic            flush;
  logic            accept;
  logic            sgn_a, sgn_b;
  logic [W-1:0]    mag_a, mag_b;
  logic [W:0]      sum, rem_sh, diff;
  logic [2*W-1:0]  prod;
  logic [W-1:0]    quo, rem;

`ifdef MULDIV_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = 1'b0;

    accept = start_i && (state_q == IDLE || state_q == DONE) && !flush;
    sgn_a  = ~op_i[0] & a_i[W-1];
    sgn_b  = ~op_i[0] & b_i[W-1];
    mag_a  = sgn_a ? (~a_i + 1'b1) : a_i;
    mag_b  = sgn_b ? (~b_i + 1'b1) : b_i;

    // Multiply: accumulator is {partial product, remaining multiplier bits}.
    sum    = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
    // Divide: accumulator is {partial remainder, dividend bits / quotient bits}.
    rem_sh = {acc_q[2*W-1:W], acc_q[W-1]};
    diff   = rem_sh - {1'b0, opnd_q};

    prod = (sa_q ^ sb_q) ? (~acc_q + 1'b1) : acc_q;
    quo  = (sa_q ^ sb_q) ? (~acc_q[W-1:0] + 1'b1) : acc_q[W-1:0];
    rem  = sa_q ? (~acc_q[2*W-1:W] + 1'b1) : acc_q[2*W-1:W];

    case (state_q)
      IDLE, DONE: begin
        if (hi_we_i) hi_d = wdata_i;
        if (lo_we_i) lo_d = wdata_i;
        if (accept) begin
          state_d = RUN;
          op_d    = op_i;
          sa_d    = sgn_a;
          sb_d    = sgn_b;
          cnt_d   = '0;
          opnd_d  = op_i[1] ? mag_b : mag_a;
          acc_d   = {{W{1'b0}}, (op_i[1] ? mag_a : mag_b)};
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          if (!op_q[1])
            acc_d = {sum, acc_q[W-1:1]};
          else if (!diff[W])
            acc_d = {diff[W-1:0], acc_q[W-2:0], 1'b1};
          else
            acc_d = {rem_sh[W-1:0], acc_q[W-2:0], 1'b0};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = FIX;
        end
      end
      FIX: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
          if (!op_q[1]) begin
            {hi_d, lo_d} = prod;
          end else begin
            // Zero divisor leaves remainder = |a|, so the sign fix restores raw a in HI.
            div_zero_d = (opnd_q == '0);
            hi_d       = rem;
            lo_d       = (opnd_q == '0) ? {W{1'b1}} : quo;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= '0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      sa_q       <= sa_d;
      sb_q       <= sb_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy_o     = (state_q == RUN) || (state_q == FIX);
  assign done_o     = (state_q == DONE);
  assign div_zero_o = div_zero_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule
